mux_nch_reg: RTL
================

Name: mux_nch_reg

Overview:
- Parametrised N-channel, W-bit registered multiplexer; successor to the 2:1 single-bit combinational mux.
- Adds per-channel valid/ready handshake, a registered output stage, and an automatic round-robin scan mode alongside manual select.
- Sits between parallel data producers and a single downstream consumer in the datapath.

Parameters:
- WIDTH, 8, data bits per channel.
- CHANNELS, 4, number of input channels; must be ≥2.
- SEL_W, 2, select/index width; must equal clog2(CHANNELS).
- DWELL, 4, cycles spent on each channel in scan mode; must be ≥1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = manual select, 1 = round-robin scan.
- sel  in  SEL_W  channel request in manual mode.
- in_data  in  CHANNELS*WIDTH  channel k at bits [k*WIDTH +: WIDTH].
- in_valid  in  CHANNELS  per-channel valid.
- in_ready  out  CHANNELS  per-channel ready (combinational).
- out_data  out  WIDTH  registered selected data.
- out_chan  out  SEL_W  index of the channel that produced out_data.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream ready.

Behaviour:
- State: cur (SEL_W bits), dwell_cnt (clog2(DWELL)+1 bits), output register {out_valid, out_data, out_chan}.
- Reset (rst=1 at edge): cur=0, dwell_cnt=0, out_valid=0, out_data=0, out_chan=0. Overrides all other activity, including a transfer in flight.
- Advance condition: adv = !out_valid || out_ready.
- in_ready[k] = adv && (k == cur). All other bits are 0. Exactly one or zero bits are high.
- Output load, when adv=1:
  - out_valid <= in_valid[cur]
  - out_data <= in_data[cur]
  - out_chan <= cur
- Output hold, when adv=0: out_valid, out_data and out_chan are held stable. No data is dropped or duplicated.
- Latency: an accepted input appears on the output 1 cycle later.
- Manual mode (mode=0):
  - When adv=1 and sel < CHANNELS: cur <= sel.
  - When sel ≥ CHANNELS (non-power-of-2 CHANNELS only): cur holds.
  - dwell_cnt is held at 0.
  - cur update and output load use the same edge: the output captures the old cur, and the new cur takes effect the next cycle.
- Scan mode (mode=1):
  - When adv=1: if dwell_cnt == DWELL-1, then cur <= (cur == CHANNELS-1) ? 0 : cur+1 and dwell_cnt <= 0. Otherwise dwell_cnt <= dwell_cnt+1.
  - When adv=0: cur and dwell_cnt freeze. The dwell period counts only non-stalled cycles.
  - Scanning runs regardless of in_valid. An idle channel still consumes its dwell slots, and out_valid=0 for those slots.
- Mode change:
  - manual→scan: dwell_cnt starts from 0; scanning begins at the current cur.
  - scan→manual: dwell_cnt is cleared to 0 on the first manual cycle; cur follows sel from that cycle.
- Simultaneous rst and any other input: rst wins.

Optional Feature:
- Macro: MUX_NCH_DEBUG_EN.
- Defined: adds output port dbg_terms [CHANNELS*WIDTH+SEL_W-1:0], a combinational debug bus.
  - Slice k is in_data[k] AND-gated by (k == cur), i.e. the per-channel product terms.
  - The top SEL_W bits carry cur.
  - OR-reducing the slices gives the next out_data.
- Not defined: port absent, no extra logic. Functional behaviour is identical in both builds.

Test Plan:
- Reset: with out_valid=1 and data 0xA5, assert rst for 1 cycle → next cycle out_valid=0, out_data=0x00, out_chan=0, in_ready=4'b0001.
- Manual select: mode=0, sel=2, in_data ch2=0x3C, in_valid=4'b0100, out_ready=1 → in_ready=4'b0100 from the cycle after sel is applied; one cycle later out_data=0x3C, out_chan=2, out_valid=1.
- Backpressure: manual on ch1 with a stream 0x10,0x11,0x12, out_ready=0 for 3 cycles after the first transfer → out_data holds 0x10, in_ready=0; on release 0x11 then 0x12 follow with none lost or repeated.
- Scan wrap: mode=1, DWELL=4, all valid, out_ready=1 → out_chan sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0; wraps from 3 to 0.
- Scan stall: mode=1 on ch1 with dwell_cnt=2, out_ready=0 for 5 cycles → cur stays 1 and dwell_cnt stays 2; after release ch1 produces exactly 2 more outputs before cur=2.
- Debug (MUX_NCH_DEBUG_EN defined): cur=3, ch3 data 0xFF, other channels 0x55 → slice 3 = 0xFF, slices 0-2 = 0x00, top bits = 3.

Source files
------------

// File: rtl/mux_nch_reg.sv
// mux_nch_reg: N-channel registered mux with per-channel valid/ready, manual select and round-robin scan.
// Define MUX_NCH_DEBUG_EN to expose the per-channel product terms and cur on dbg_terms.
module mux_nch_reg #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef MUX_NCH_DEBUG_EN
    ,
    output logic [CHANNELS*WIDTH+SEL_W-1:0] dbg_terms
`endif
);

    localparam int               CNT_W   = $clog2(DWELL) + 1;
    localparam int               SEL_N   = 1 << SEL_W;
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);
    localparam logic [CNT_W-1:0] LAST_DW = CNT_W'(DWELL - 1);

    logic [SEL_W-1:0]          cur;
    logic [CNT_W-1:0]          dwell_cnt;
    logic                      adv;
    logic [CHANNELS*WIDTH-1:0] terms;
    logic [WIDTH-1:0]          nxt_data;
    logic                      nxt_valid;
    logic [SEL_N-1:0]          sel_legal;

    assign adv = !out_valid || out_ready;

    // Select is an AND-OR tree of per-channel product terms gated by cur.
    always_comb begin
        in_ready  = '0;
        terms     = '0;
        nxt_data  = '0;
        nxt_valid = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (cur == SEL_W'(k)) begin
                in_ready[k]              = adv;
                terms[k*WIDTH +: WIDTH]  = in_data[k*WIDTH +: WIDTH];
                nxt_valid                = in_valid[k];
            end
            nxt_data = nxt_data | terms[k*WIDTH +: WIDTH];
        end
    end

    // Codes at or beyond CHANNELS exist only for non-power-of-2 channel counts.
    always_comb begin
        sel_legal = '0;
        for (int k = 0; k < SEL_N; k++) begin
            sel_legal[k] = (k < CHANNELS);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur       <= '0;
            dwell_cnt <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else begin
            if (adv) begin
                out_valid <= nxt_valid;
                out_data  <= nxt_data;
                out_chan  <= cur;
            end
            if (!mode) begin
                dwell_cnt <= '0;
                if (adv && sel_legal[sel]) begin
                    cur <= sel;
                end
            end else if (adv) begin
                if (dwell_cnt == LAST_DW) begin
                    dwell_cnt <= '0;
                    cur       <= (cur == LAST_CH) ? '0 : cur + 1'b1;
                end else begin
                    dwell_cnt <= dwell_cnt + 1'b1;
                end
            end
        end
    end

`ifdef MUX_NCH_DEBUG_EN
    assign dbg_terms = {cur, terms};
`endif

endmodule
